// File: rtl/program_loader.sv
// Boot loader: assembles little-endian words from a byte stream into instruction memory and holds the core in reset until the image is complete.
// Optional trailer checksum verification is compiled in with `define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MAX_WORDS = 64,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 reload,
  output logic                 imem_we,
  output logic [63:0]          imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset,
  output logic                 load_done,
  output logic                 load_error,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_lo;
  logic [31:0] word_total;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;
  logic        last_word;
  logic [63:0] next_addr;

  // Byte assembly: the 4th byte completes the word combinationally
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_idx == 2'd3);
  assign word_full = {in_data, asm_lo};
  assign last_word = (32'(words_loaded) + 32'd1) == word_total;
  assign next_addr = BASE_ADDR + (64'(words_loaded) << 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_HDR;
      byte_idx     <= 2'd0;
      asm_lo       <= 24'd0;
      word_total   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      checksum     <= 32'd0;
`endif
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else if (reload) begin
      state        <= S_HDR;
      byte_idx     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      checksum     <= 32'd0;
`endif
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_lo[7:0]   <= in_data;
          2'd1:    asm_lo[15:8]  <= in_data;
          2'd2:    asm_lo[23:16] <= in_data;
          default: ;
        endcase
      end
      // Control stage: state transitions and the registered write strobe
      case (state)
        S_HDR: begin
          if (last_byte) begin
            word_total <= word_full;
            if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_DONE;
              load_done <= 1'b1;
              in_ready  <= 1'b0;
`endif
            end else if (word_full > 32'(MAX_WORDS)) begin
              state      <= S_ERROR;
              load_error <= 1'b1;
              in_ready   <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (last_byte) begin
            imem_we      <= 1'b1;
            imem_addr    <= next_addr;
            imem_wdata   <= word_full;
            words_loaded <= words_loaded + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= checksum + word_full;
            if (last_word) state <= S_CHK;
`else
            if (last_word) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              in_ready  <= 1'b0;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (last_byte) begin
            in_ready <= 1'b0;
            if (word_full == checksum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          // Released one cycle after entry so the final write commits first
          core_reset <= 1'b0;
        end
        S_ERROR: ;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed boot scenarios plus randomized images checked against a stream-parsing reference model.
module tb_program_loader;

  localparam logic [63:0] BASE_ADDR = 64'd0;
  localparam int          MAX_WORDS = 64;
  localparam int          CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 reload;
  logic                 imem_we;
  logic [63:0]          imem_addr;
  logic [31:0]          imem_wdata;
  logic                 core_reset;
  logic                 load_done;
  logic                 load_error;
  logic [CNT_WIDTH-1:0] words_loaded;

  program_loader #(
    .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  img[$];
  logic [95:0] wr_q[$];
  logic [95:0] exp_q[$];
  int          exp_consumed;
  bit          exp_done;
  bit          exp_err;
  int          exp_words;

  always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] get_word(input int idx);
    return {img[idx+3], img[idx+2], img[idx+1], img[idx]};
  endfunction

  // Reference: parse the byte image by the loader's rules
  task automatic model_image();
    logic [31:0] n;
    logic [31:0] sum;
    exp_q.delete();
    n = get_word(0);
    sum = 32'd0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > 32'(MAX_WORDS)) begin
      exp_err = 1'b1;
      exp_consumed = 4;
      exp_words = 0;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        exp_q.push_back({BASE_ADDR + 64'(4 * k), get_word(4 + 4 * k)});
        sum = sum + get_word(4 + 4 * k);
      end
      exp_words = int'(n);
      exp_consumed = 4 + 4 * int'(n);
`ifdef LOADER_CHECKSUM_EN
      exp_done = (get_word(exp_consumed) == sum);
      exp_err  = !exp_done;
      exp_consumed += 4;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output bit acc);
    in_valid = 1'b1;
    in_data  = b;
    acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_reload(input bit with_byte);
    reload   = 1'b1;
    in_valid = with_byte;
    in_data  = 8'($urandom);
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_image(input string tag, input bit rl, input int gap_lo, input int gap_hi);
    int consumed;
    bit acc;
    if (rl) do_reload(1'b1);
    wr_q.delete();
    model_image();
    consumed = 0;
    foreach (img[i]) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
      push_byte(img[i], acc);
      consumed += int'(acc);
    end
    repeat (2) @(negedge clk);
    check({tag, ".consumed"}, 96'(consumed), 96'(exp_consumed));
    check({tag, ".nwrites"}, 96'(wr_q.size()), 96'(exp_q.size()));
    foreach (exp_q[i]) check({tag, ".write"}, (i < wr_q.size()) ? wr_q[i] : 96'hx, exp_q[i]);
    check({tag, ".done"}, 96'(load_done), 96'(exp_done));
    check({tag, ".error"}, 96'(load_error), 96'(exp_err));
    check({tag, ".core_reset"}, 96'(core_reset), 96'(!exp_done));
    check({tag, ".words"}, 96'(words_loaded), 96'(exp_words));
    check({tag, ".in_ready"}, 96'(in_ready), 96'd0);
    check({tag, ".we_idle"}, 96'(imem_we), 96'd0);
    if (exp_q.size() > 0) check({tag, ".addr_hold"}, 96'(imem_addr), 96'(exp_q[exp_q.size()-1][95:32]));
  endtask

  task automatic build_two_word(input logic [31:0] trailer);
    img.delete();
    put_word(32'd2);
    put_word(32'h00500013);
    put_word(32'h00A00093);
`ifdef LOADER_CHECKSUM_EN
    put_word(trailer);
`else
    if (trailer != 32'd0) put_word(trailer);
`endif
    img.push_back(8'h5A);
  endtask

  task automatic build_random();
    int          kind;
    logic [31:0] n;
    logic [31:0] w;
    logic [31:0] sum;
    kind = $urandom_range(0, 5);
    if (kind == 0) n = 32'd0;
    else if (kind == 1) n = 32'(MAX_WORDS);
    else if (kind == 2) n = 32'(MAX_WORDS + 1 + $urandom_range(0, 3));
    else n = 32'($urandom_range(1, 6));
    img.delete();
    put_word(n);
    sum = 32'd0;
    if (n <= 32'(MAX_WORDS)) begin
      for (int k = 0; k < int'(n); k++) begin
        w = $urandom;
        put_word(w);
        sum = sum + w;
      end
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) sum = sum ^ 32'($urandom_range(1, 255));
      put_word(sum);
`endif
    end
    img.push_back(8'($urandom));
    img.push_back(8'($urandom));
  endtask

  initial begin
    bit acc;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(negedge clk);

    check("rst.in_ready", 96'(in_ready), 96'd1);
    check("rst.we", 96'(imem_we), 96'd0);
    check("rst.addr", 96'(imem_addr), 96'(BASE_ADDR));
    check("rst.wdata", 96'(imem_wdata), 96'd0);
    check("rst.core_reset", 96'(core_reset), 96'd1);
    check("rst.done", 96'(load_done), 96'd0);
    check("rst.error", 96'(load_error), 96'd0);
    check("rst.words", 96'(words_loaded), 96'd0);
    reset = 1'b1;
    @(negedge clk);

    // Gapless two-word image with cycle-exact observation
    build_two_word(32'h00F000A6);
    for (int i = 0; i < 12; i++) begin
      push_byte(img[i], acc);
      check("t1.accept", 96'(acc), 96'd1);
      if (i == 7) begin
        check("t1.w0.we", 96'(imem_we), 96'd1);
        check("t1.w0", {imem_addr, imem_wdata}, {BASE_ADDR, 32'h00500013});
        check("t1.w0.words", 96'(words_loaded), 96'd1);
      end
    end
    check("t1.w1.we", 96'(imem_we), 96'd1);
    check("t1.w1", {imem_addr, imem_wdata}, {BASE_ADDR + 64'd4, 32'h00A00093});
    check("t1.w1.words", 96'(words_loaded), 96'd2);
`ifdef LOADER_CHECKSUM_EN
    check("t1.chk.done_early", 96'(load_done), 96'd0);
    for (int i = 12; i < 16; i++) push_byte(img[i], acc);
`endif
    check("t1.done", 96'(load_done), 96'd1);
    check("t1.core_reset_held", 96'(core_reset), 96'd1);
    @(negedge clk);
    check("t1.core_released", 96'(core_reset), 96'd0);
    check("t1.we_pulse", 96'(imem_we), 96'd0);
    check("t1.wdata_hold", 96'(imem_wdata), 96'h00A00093);
    push_byte(8'h77, acc);
    check("t1.idle_byte", 96'(acc), 96'd0);
    check("t1.words_hold", 96'(words_loaded), 96'd2);

    // Same image with in_valid toggling every other cycle
    run_image("t2", 1'b1, 1, 1);

    // Header count one above capacity
    img.delete();
    put_word(32'h00000041);
    put_word(32'h12345678);
    run_image("t3", 1'b1, 0, 1);

    // Capacity-bound header at exactly MAX_WORDS and the empty image
    img.delete();
    put_word(32'(MAX_WORDS));
    for (int k = 0; k < MAX_WORDS; k++) put_word(32'($urandom));
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [31:0] s;
      s = 32'd0;
      for (int k = 0; k < MAX_WORDS; k++) s = s + get_word(4 + 4 * k);
      put_word(s);
    end
`endif
    run_image("t4max", 1'b1, 0, 0);
    img.delete();
    put_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    put_word(32'd0);
`endif
    img.push_back(8'hEE);
    run_image("t4zero", 1'b1, 0, 2);

    // Reload after a partial second word, byte in the reload cycle discarded
    do_reload(1'b0);
    wr_q.delete();
    build_two_word(32'h00F000A6);
    for (int i = 0; i < 10; i++) push_byte(img[i], acc);
    repeat (2) @(negedge clk);
    check("t5.pre_writes", 96'(wr_q.size()), 96'd1);
    do_reload(1'b1);
    repeat (2) @(negedge clk);
    check("t5.words_cleared", 96'(words_loaded), 96'd0);
    check("t5.core_reset", 96'(core_reset), 96'd1);
    check("t5.in_ready", 96'(in_ready), 96'd1);
    check("t5.no_partial", 96'(wr_q.size()), 96'd1);
    run_image("t5", 1'b0, 0, 1);

    // Asynchronous reset right after word 0 is written
    do_reload(1'b0);
    for (int i = 0; i < 8; i++) push_byte(img[i], acc);
    check("t6.we_before", 96'(imem_we), 96'd1);
    #2 reset = 1'b0;
    #1;
    check("t6.we", 96'(imem_we), 96'd0);
    check("t6.addr", 96'(imem_addr), 96'(BASE_ADDR));
    check("t6.wdata", 96'(imem_wdata), 96'd0);
    check("t6.words", 96'(words_loaded), 96'd0);
    check("t6.core_reset", 96'(core_reset), 96'd1);
    check("t6.in_ready", 96'(in_ready), 96'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_image("t6", 1'b0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    build_two_word(32'd0);
    run_image("t7bad", 1'b1, 0, 1);
`endif

    for (int r = 0; r < 8; r++) begin
      build_random();
      run_image("rand", 1'b1, 0, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle core.
- Receives a byte stream over a valid/ready link and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory write port, holding the core in reset until the image is complete.
- On success it releases core_reset, so the core's PC starts at BASE_ADDR on a populated instruction memory.

Parameters:
BASE_ADDR, 64'd0, byte address of the first instruction word written.
MAX_WORDS, 64, instruction memory capacity in 32-bit words. A header count above this is an error.
CNT_WIDTH, 16, width of the word counter and of the words_loaded port.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle pulse: restart loading from the header
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  64  byte address of the word being written
imem_wdata  output  32  instruction word
core_reset  output  1  active-high reset to the core; 1 until the load succeeds
load_done  output  1  image loaded successfully (sticky)
load_error  output  1  load failed (sticky)
words_loaded  output  CNT_WIDTH  number of words written so far

Behaviour:
- Reset values: state HDR, in_ready 1, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, core_reset 1, load_done 0, load_error 0, words_loaded 0. Byte index and checksum accumulator are cleared.
- Handshake:
  - A byte is accepted only when in_valid && in_ready.
  - in_ready = 1 in HDR, LOAD and CHK; 0 in DONE and ERROR.
  - in_data is ignored when no byte is accepted.
- Byte assembly: 2-bit byte index; the first accepted byte of a group is bits [7:0], the fourth is bits [31:24].
- HDR state:
  - Collects 4 bytes to form the word count N.
  - On the 4th byte: N == 0 -> DONE; N > MAX_WORDS -> ERROR; otherwise -> LOAD.
- LOAD state:
  - On the 4th byte of word k (0-based), the next cycle shows imem_we = 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*k and imem_wdata = the assembled word.
  - words_loaded increments in that same cycle.
  - Latency from accepting the last byte to imem_we is 1 cycle.
  - After word N-1: go to DONE, or to CHK when the optional feature is compiled in.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- DONE state:
  - load_done = 1, entered in the same cycle as the final imem_we.
  - core_reset falls one cycle later, so the core never fetches before the last write commits.
- ERROR state: load_error = 1, core_reset stays 1, no further writes.
- reload pulse in any state:
  - Next state is HDR; core_reset = 1, load_done = 0, load_error = 0, words_loaded = 0.
  - Byte index and checksum are cleared.
  - A byte accepted in the same cycle as reload is discarded.
  - Any partial word is dropped and no imem_we is issued for it.
- Asynchronous reset mid-load: immediate return to the reset values; partially written memory contents are left as is.
- Counters are unsigned CNT_WIDTH bits. Addresses use 64-bit modular addition.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator adds each data word modulo 2^32; the header is not included.
  - After the last word, CHK collects a 4-byte little-endian trailer.
  - Trailer equals the sum -> DONE; otherwise -> ERROR.
  - For N == 0, CHK is still entered and the expected trailer is 0.
- Undefined: no accumulator, no CHK state; LOAD goes straight to DONE and no trailer is consumed.

Test Plan:
- Stream 02 00 00 00, 13 00 50 00, 93 00 A0 00 with no gaps -> imem_we at addr 0 data 0x00500013, then at addr 4 data 0x00A00093. words_loaded = 2, load_done = 1, core_reset falls 1 cycle after the second write.
- Same image with in_valid toggling every other cycle, plus an idle in_valid = 1 byte after DONE -> identical writes; in_ready = 0 in DONE and the extra byte is not consumed.
- Header 0x00000041 (65 > MAX_WORDS = 64) -> ERROR after the 4th header byte; load_error = 1, core_reset stays 1, no imem_we.
- reload after 6 data bytes of a 2-word image, then the full image -> no write for the aborted partial word. Restarted load writes addr 0/4 correctly; words_loaded restarts at 0.
- Assert reset low mid-LOAD at word 1 -> all outputs at reset values asynchronously, without waiting for a clock edge; a new full stream loads correctly.
- LOADER_CHECKSUM_EN, 2-word image above:
  - Trailer A6 00 F0 00 (0x00F000A6) -> DONE.
  - Trailer 00 00 00 00 -> ERROR with core_reset held at 1.
